up: RTL and testbench

Top level of the Nibbler-style 4-bit microprocessor: 12-bit program counter, 4 K×8 program ROM, 4 K×4 data RAM, 4-bit accumulator with carry/zero flags, and a two-phase fetch/execute sequencer. Pushbuttons are the input port and a 4-bit output register is the output port. All internal state is exported for debug and waveform inspection.

---
 rtl/nibbler_pkg.sv | 36 +++
 rtl/nibbler_alu.sv | 43 ++++
 rtl/up.sv | 151 +++++++++++++++
 tb/tb_up.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Nibbler shared definitions: opcodes,
// ALU operations and instruction length.
package nibbler_pkg;

   localparam logic [3:0] JC    = 4'h0;
   localparam logic [3:0] JNC   = 4'h1;
   localparam logic [3:0] CMPI  = 4'h2;
   localparam logic [3:0] CMPM  = 4'h3;
   localparam logic [3:0] LIT   = 4'h4;
   localparam logic [3:0] IN    = 4'h5;
   localparam logic [3:0] LD    = 4'h6;
   localparam logic [3:0] ST    = 4'h7;
   localparam logic [3:0] JZ    = 4'h8;
   localparam logic [3:0] JNZ   = 4'h9;
   localparam logic [3:0] ADDI  = 4'hA;
   localparam logic [3:0] ADDM  = 4'hB;
   localparam logic [3:0] JMP   = 4'hC;
   localparam logic [3:0] OUT   = 4'hD;
   localparam logic [3:0] NANDI = 4'hE;
   localparam logic [3:0] NANDM = 4'hF;

   typedef enum logic [1:0] {
      PASS_B,
      SUB,
      ADD,
      NAND
   } alu_op_t;

   function automatic logic is_two_byte(
      input logic [3:0] op
   );
      return op inside {JC, JNC, CMPM, LD, ST,
                        JZ, JNZ, ADDM, JMP, NANDM};
   endfunction

endpackage

// File: rtl/nibbler_alu.sv
// Nibbler 4-bit ALU: pass, compare,
// add and nand with carry/zero outputs.
module nibbler_alu
   import nibbler_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  alu_op_t    op,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero
);

   logic [4:0] sum;

   // Result and carry for the selected operation
   always_comb begin
      sum    = 5'd0;
      result = b;
      carry  = 1'b0;
      case (op)
         ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[3:0];
            carry  = sum[4];
         end
         SUB: begin
            sum    = {1'b0, a} + {1'b0, ~b} + 5'd1;
            result = sum[3:0];
            carry  = sum[4];
         end
         NAND: begin
            result = ~(a & b);
         end
         default: begin
            result = b;
         end
      endcase
   end

   assign zero = (result == 4'h0);

endmodule

// File: rtl/up.sv
// Nibbler 4-bit microprocessor top: ROM, RAM,
// accumulator, flags and fetch/execute sequencer.
module up
   import nibbler_pkg::*;
#(
   parameter string ROM_FILE = "memory.list"
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  pushbuttons,
   output logic        phase,
   output logic        c_flag,
   output logic        z_flag,
   output logic [3:0]  instr,
   output logic [3:0]  oprnd,
   output logic [3:0]  data_bus,
   output logic [3:0]  FF_out,
   output logic [3:0]  accu,
   output logic [7:0]  program_byte,
   output logic [11:0] PC,
   output logic [11:0] address_RAM
);

   logic [7:0] rom [4096];
   logic [3:0] ram [4096];

   logic [3:0] mem_q;
   logic [3:0] alu_res;
   logic       alu_c;
   logic       alu_z;
   alu_op_t    alu_op;
   logic       flag_we;
   logic       acc_we;
   logic       jump;

   assign program_byte = rom[PC];
   assign address_RAM  = {oprnd, program_byte};
   assign mem_q        = ram[address_RAM];

   // Execute-phase decode: bus source, ALU op, enables
   always_comb begin
      alu_op   = PASS_B;
      flag_we  = 1'b0;
      acc_we   = 1'b0;
      jump     = 1'b0;
      data_bus = 4'h0;
      if (phase) begin
         unique case (instr)
            JC:    jump = c_flag;
            JNC:   jump = !c_flag;
            JZ:    jump = z_flag;
            JNZ:   jump = !z_flag;
            JMP:   jump = 1'b1;
            CMPI: begin
               data_bus = oprnd;
               alu_op   = SUB;
               flag_we  = 1'b1;
            end
            CMPM: begin
               data_bus = mem_q;
               alu_op   = SUB;
               flag_we  = 1'b1;
            end
            LIT: begin
               data_bus = oprnd;
               acc_we   = 1'b1;
            end
            IN: begin
               data_bus = pushbuttons;
               acc_we   = 1'b1;
            end
            LD: begin
               data_bus = mem_q;
               acc_we   = 1'b1;
            end
            ST:    data_bus = accu;
            OUT:   data_bus = accu;
            ADDI: begin
               data_bus = oprnd;
               alu_op   = ADD;
               flag_we  = 1'b1;
               acc_we   = 1'b1;
            end
            ADDM: begin
               data_bus = mem_q;
               alu_op   = ADD;
               flag_we  = 1'b1;
               acc_we   = 1'b1;
            end
            NANDI: begin
               data_bus = oprnd;
               alu_op   = NAND;
               flag_we  = 1'b1;
               acc_we   = 1'b1;
            end
            NANDM: begin
               data_bus = mem_q;
               alu_op   = NAND;
               flag_we  = 1'b1;
               acc_we   = 1'b1;
            end
         endcase
      end
   end

   nibbler_alu u_alu (
      .a      (accu),
      .b      (data_bus),
      .op     (alu_op),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );

   // Two-phase sequencer and architectural registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         PC     <= 12'h000;
         phase  <= 1'b0;
         accu   <= 4'h0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
         instr  <= 4'h0;
         oprnd  <= 4'h0;
         FF_out <= 4'h0;
      end else if (!phase) begin
         {instr, oprnd} <= program_byte;
         PC             <= PC + 12'd1;
         phase          <= 1'b1;
      end else begin
         phase <= 1'b0;
         if (is_two_byte(instr))
            PC <= jump ? address_RAM : PC + 12'd1;
         if (acc_we)
            accu <= alu_res;
         if (flag_we) begin
            c_flag <= alu_c;
            z_flag <= alu_z;
         end
         if (instr == OUT)
            FF_out <= accu;
      end
   end

   // Data RAM write, only for ST in execute
   always_ff @(posedge clock) begin
      if (reset && phase && instr == ST)
         ram[address_RAM] <= accu;
   end

endmodule

// File: tb/tb_up.sv
// Self-checking bench for the Nibbler top:
// vector table, corner sequences, random model.
module tb_up;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  pushbuttons = 4'h0;
   logic        phase, c_flag, z_flag;
   logic [3:0]  instr, oprnd, data_bus;
   logic [3:0]  FF_out, accu;
   logic [7:0]  program_byte;
   logic [11:0] PC, address_RAM;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] rom_m [4096];
   logic [3:0] ram_m [4096];

   up #(.ROM_FILE("")) dut (
      .clock        (clock),
      .reset        (reset),
      .pushbuttons  (pushbuttons),
      .phase        (phase),
      .c_flag       (c_flag),
      .z_flag       (z_flag),
      .instr        (instr),
      .oprnd        (oprnd),
      .data_bus     (data_bus),
      .FF_out       (FF_out),
      .accu         (accu),
      .program_byte (program_byte),
      .PC           (PC),
      .address_RAM  (address_RAM)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [47:0] prog;
      int          len;
      logic [3:0]  pb;
      int          cycles;
      logic [11:0] pc;
      logic [3:0]  a;
      logic        c;
      logic        z;
      logic [3:0]  ff;
   } vec_t;

   vec_t v [12];

   task automatic chk(input string name,
                      input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic put(input int addr,
                      input logic [7:0] val);
      dut.rom[addr] = val;
      rom_m[addr]   = val;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) put(i, 8'h00);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   // Instruction-level reference model state
   int m_pc, m_a, m_c, m_z, m_ff;

   task automatic model_step(input int pb,
                             output int e_db,
                             output int e_addr,
                             output int two);
      int op, imm, pc1, addr, m, npc, s;
      op   = rom_m[m_pc] >> 4;
      imm  = rom_m[m_pc] & 15;
      pc1  = (m_pc + 1) % 4096;
      two  = (op inside {0, 1, 3, 6, 7, 8, 9,
                         11, 12, 15}) ? 1 : 0;
      addr = imm * 256 + rom_m[pc1];
      m    = ram_m[addr];
      npc  = two ? (pc1 + 1) % 4096 : pc1;
      e_db = 0;
      e_addr = addr;
      case (op)
         0:  if (m_c)  npc = addr;
         1:  if (!m_c) npc = addr;
         8:  if (m_z)  npc = addr;
         9:  if (!m_z) npc = addr;
         12: npc = addr;
         2, 3: begin
            e_db = (op == 2) ? imm : m;
            m_c = (m_a >= e_db) ? 1 : 0;
            m_z = (m_a == e_db) ? 1 : 0;
         end
         4: begin e_db = imm; m_a = imm; end
         5: begin e_db = pb;  m_a = pb;  end
         6: begin e_db = m;   m_a = m;   end
         7: begin e_db = m_a; ram_m[addr] = m_a[3:0]; end
         13: begin e_db = m_a; m_ff = m_a; end
         10, 11: begin
            e_db = (op == 10) ? imm : m;
            s = m_a + e_db;
            m_c = (s > 15) ? 1 : 0;
            m_a = s % 16;
            m_z = (m_a == 0) ? 1 : 0;
         end
         default: begin
            e_db = (op == 14) ? imm : m;
            m_a = 15 - (m_a & e_db);
            m_c = 0;
            m_z = (m_a == 0) ? 1 : 0;
         end
      endcase
      m_pc = npc;
   endtask

   initial begin
      int e_db, e_addr, two, op, b;

      v[0]  = '{48'h45A3A8000000, 3, 4'h0, 6,
                12'h003, 4'h0, 1'b1, 1'b1, 4'h0};
      v[1]  = '{48'h50D000000000, 2, 4'hF, 4,
                12'h002, 4'hF, 1'b0, 1'b0, 4'hF};
      v[2]  = '{48'h477020406020, 6, 4'h0, 8,
                12'h006, 4'h7, 1'b0, 1'b0, 4'h0};
      v[3]  = '{48'hC12300000000, 2, 4'h0, 2,
                12'h123, 4'h0, 1'b0, 1'b0, 4'h0};
      v[4]  = '{48'h912300000000, 2, 4'h0, 2,
                12'h123, 4'h0, 1'b0, 1'b0, 4'h0};
      v[5]  = '{48'h812300000000, 2, 4'h0, 2,
                12'h002, 4'h0, 1'b0, 1'b0, 4'h0};
      v[6]  = '{48'h432300000000, 2, 4'h0, 4,
                12'h002, 4'h3, 1'b1, 1'b1, 4'h0};
      v[7]  = '{48'h432324000000, 3, 4'h0, 6,
                12'h003, 4'h3, 1'b0, 1'b0, 4'h0};
      v[8]  = '{48'h4FE500000000, 2, 4'h0, 4,
                12'h002, 4'hA, 1'b0, 1'b0, 4'h0};
      v[9]  = '{48'h4FEF00000000, 2, 4'h0, 4,
                12'h002, 4'h0, 1'b0, 1'b1, 4'h0};
      v[10] = '{48'h4FAF00100000, 4, 4'h0, 6,
                12'h010, 4'hE, 1'b1, 1'b0, 4'h0};
      v[11] = '{48'h4F2F10400000, 4, 4'h0, 6,
                12'h004, 4'hF, 1'b1, 1'b1, 4'h0};

      // Vector table
      for (int k = 0; k < 12; k++) begin
         reset = 1'b0;
         clear_rom();
         for (int i = 0; i < v[k].len; i++)
            put(i, v[k].prog[47 - 8 * i -: 8]);
         pushbuttons = v[k].pb;
         do_reset();
         repeat (v[k].cycles) @(negedge clock);
         chk($sformatf("v%0d_pc", k), PC, v[k].pc);
         chk($sformatf("v%0d_accu", k), accu, v[k].a);
         chk($sformatf("v%0d_c", k), c_flag, v[k].c);
         chk($sformatf("v%0d_z", k), z_flag, v[k].z);
         chk($sformatf("v%0d_ff", k), FF_out, v[k].ff);
      end

      // IN/OUT bus values
      clear_rom();
      put(0, 8'h50);
      put(1, 8'hD0);
      pushbuttons = 4'hF;
      do_reset();
      chk("io_bus_fetch", data_bus, 0);
      @(negedge clock);
      chk("io_phase", phase, 1);
      chk("io_instr", instr, 5);
      chk("io_bus_in", data_bus, 4'hF);
      @(negedge clock);
      chk("io_accu", accu, 4'hF);
      @(negedge clock);
      chk("io_bus_out", data_bus, 4'hF);
      @(negedge clock);
      chk("io_ff", FF_out, 4'hF);

      // ST address and bus during execute
      clear_rom();
      put(0, 8'h47);
      put(1, 8'h70);
      put(2, 8'h20);
      do_reset();
      repeat (3) @(negedge clock);
      chk("st_addr", address_RAM, 12'h020);
      chk("st_bus", data_bus, 4'h7);

      // Reset mid-instruction aborts OUT
      clear_rom();
      put(0, 8'h4F);
      put(1, 8'hD0);
      do_reset();
      repeat (3) @(negedge clock);
      chk("mid_phase", phase, 1);
      chk("mid_accu_pre", accu, 4'hF);
      do_reset();
      chk("rst_pc", PC, 0);
      chk("rst_phase", phase, 0);
      chk("rst_accu", accu, 0);
      chk("rst_c", c_flag, 0);
      chk("rst_z", z_flag, 0);
      chk("rst_ff", FF_out, 0);
      chk("rst_instr", instr, 0);
      chk("rst_oprnd", oprnd, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("alt_phase%0d", i), phase, i % 2);
         @(negedge clock);
      end

      // PC wrap and 2-byte op at 0xFFF
      clear_rom();
      put(0, 8'hCF);
      put(1, 8'hFF);
      put(4095, 8'hC0);
      do_reset();
      repeat (2) @(negedge clock);
      chk("wrap_pc_fff", PC, 12'hFFF);
      @(negedge clock);
      chk("wrap_pc0", PC, 12'h000);
      chk("wrap_addr", address_RAM, 12'h0CF);
      @(negedge clock);
      chk("wrap_jmp", PC, 12'h0CF);

      // Random program vs model; prefix fills RAM
      reset = 1'b0;
      for (int k = 0; k < 256; k++) begin
         put(3 * k, 8'h40 | 8'($urandom_range(0, 15)));
         put(3 * k + 1, 8'h70);
         put(3 * k + 2, 8'(k));
      end
      for (int i = 768; i < 4096; i++) begin
         b  = $urandom_range(0, 255);
         op = b >> 4;
         if (op inside {3, 6, 7, 11, 15})
            b = b & 8'hF0;
         if (op inside {0, 1, 8, 9, 12})
            b = (b & 8'hF0) | $urandom_range(3, 15);
         put(i, 8'(b));
      end
      do_reset();
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_ff = 0;
      for (int n = 0; n < 1000; n++) begin
         pushbuttons = 4'($urandom_range(0, 15));
         model_step(int'(pushbuttons), e_db, e_addr, two);
         @(negedge clock);
         chk("rnd_phase", phase, 1);
         chk("rnd_bus", data_bus, e_db);
         if (two != 0)
            chk("rnd_addr", address_RAM, e_addr);
         @(negedge clock);
         chk("rnd_pc", PC, m_pc);
         chk("rnd_accu", accu, m_a);
         chk("rnd_c", c_flag, m_c);
         chk("rnd_z", z_flag, m_z);
         chk("rnd_ff", FF_out, m_ff);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
